divmod_arb: RTL and testbench
=============================

# divmod_arb

Round-robin arbiter and sequencer that shares one `divmod` unit among `NREQ` independent requesters. It captures the winning requester's operands, issues a single-cycle `go` to the divider, and tracks the divider's registered `ready`/`error` handshake. It then returns the quotient, remainder and error flag on shared result buses with a one-hot completion pulse. It sits between the prime-search control logic (several trial-division lanes) and the single divider instance.

## Interface
- `WIDTH_LOG`, 4, operand width is `WIDTH = 1 << WIDTH_LOG`
- `NREQ`, 4, number of requesters, 2..16
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high; also drives the internal `divmod` reset
- `req`  in  NREQ  level request per requester
- `a_in`  in  NREQ*WIDTH  flattened dividends; requester i uses bits [i*WIDTH +: WIDTH]
- `b_in`  in  NREQ*WIDTH  flattened divisors, same packing
- `gnt`  out  NREQ  one-hot; the requester whose operation is in flight; 0 when idle
- `done`  out  NREQ  one-hot single-cycle completion pulse
- `busy`  out  1  high from capture until `done`
- `err`  out  1  divide-by-zero flag; valid while `done` != 0
- `div`  out  WIDTH  quotient; valid while `done` != 0, held afterwards
- `mod`  out  WIDTH  remainder; same validity as `div`

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE
  - Form the eligible mask as `req` with the bit of the current `done` pulse cleared. This prevents re-granting a requester in the cycle it is acknowledged.
  - If the mask is nonzero, pick the first set bit at or after `ptr`, searching upward with wrap-around.
  - Register the winner id, `a_q`/`b_q`, `gnt`, and `busy=1`, then go to ISSUE.
- ISSUE
  - Drive `go=1` to `divmod` with `a_q`/`b_q` for exactly one cycle, then go to WAIT.
  - The divider is always ready in IDLE/ISSUE by construction, so `go` is never issued while it is computing.
- WAIT
  - `divmod` `ready` is registered from its next state. In the first WAIT cycle `ready` is therefore already 0 (computing) or 1 with `error=1` (b==0). No extra wait cycle is inserted.
  - When `ready`=1: register `div`, `mod` and `err` from the divider. Set `done[id]=1` for one cycle, clear `gnt` and `busy`, set `ptr = (id+1) mod NREQ`, and go to IDLE.
- The requester must hold `req` until it sees its `done` bit. It may keep `req` high to queue another operation; the pointer gives every other requester priority first.
- Operands are captured once. Changing `a_in`/`b_in` or dropping `req` after capture does not affect the in-flight operation, and `done` is still pulsed.
- `ptr` has `ceil(log2 NREQ)` bits and wraps from NREQ-1 to 0. `NREQ` does not need to be a power of 2.

## Timing
- Reset values: `gnt=0`, `done=0`, `busy=0`, `err=0`, `div=0`, `mod=0`, `ptr=0`, state IDLE.
- `rst` mid-operation aborts the operation: no `done` pulse, all outputs return to their reset values, and the divider is reset in the same cycle.
- Request at cycle t in IDLE gives: `gnt`/`busy` high at t+1 (ISSUE), `go` at t+1, WAIT from t+2.
- Minimum latency is for b==0: `ready`/`error` seen at t+2 and `done` at t+3.
- Nonzero divisor: `done` comes one cycle after `divmod` raises `ready`.
- The `done` cycle is an IDLE cycle, so a new grant can be captured in that same cycle. Back-to-back throughput is one operation per (divmod latency + 3) cycles.
- Requests arriving during ISSUE/WAIT wait for the next IDLE. There is no preemption.

## Structure
- Shared package/defines header holds the state encodings (IDLE/ISSUE/WAIT) and the `WIDTH` derivation from `WIDTH_LOG`, shared with `divmod`.
- Sub-module `rr_pick`: combinational round-robin picker taking mask and pointer, producing one-hot grant, id and `any`.
- One `divmod` instance with `WIDTH_LOG` passed through.

## Test plan
- Requester 0 only, a=100, b=7 -> `done=0001`, `div=14`, `mod=2`, `err=0`; `gnt=0001` from capture through WAIT.
- Requester 2, a=5, b=0 -> `done=0100` exactly 3 cycles after `req`, `err=1`.
- All four `req` high from reset, each with a=0x00FF, b=0x0010 -> completion order 0,1,2,3, each `div=15`, `mod=15`, no requester granted twice before all four are served.
- Requester 1 keeps `req` high after `done`, requester 3 requests -> next grant is 3, then 1. Requester 1 alone kept high -> re-granted without a duplicate grant in its `done` cycle.
- Change `a_in`/`b_in` and drop `req` one cycle after capture -> result uses the captured operands and `done` still pulses.
- Assert `rst` during WAIT -> no `done`, all outputs 0 next cycle; a fresh request afterwards completes correctly with the grant starting from requester 0.

Source files
------------

// File: rtl/divmod_arb_pkg.sv
// Shared definitions for the divider arbiter and the divmod unit.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
//
// Holds the arbiter state encoding and the operand width derivation so the
// arbiter and the divider agree on WIDTH = 1 << WIDTH_LOG.
package divmod_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Operand width derived from its log2.
    function automatic int width_of(input int width_log);
        return 1 << width_log;
    endfunction

endpackage

// File: rtl/divmod.sv
// Unsigned restoring divider producing quotient and remainder.
// Latency: b==0 answers on the go edge (ready stays 1, error=1); otherwise ready drops for WIDTH cycles.
// Backpressure: go is only legal while ready=1; the caller must not issue while computing.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   go            single-cycle start strobe, sampled with a/b
//   a, b          dividend, divisor
//   div, mod      quotient, remainder; valid while ready=1 after an operation
//   ready         registered from the next state: 1 when idle, 0 while computing
//   error         divide-by-zero flag of the last operation
module divmod
    import divmod_arb_pkg::*;
#(
    parameter int WIDTH_LOG = 4,
    localparam int WIDTH = width_of(WIDTH_LOG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] mod,
    output logic             ready,
    output logic             error
);

    localparam int CW = WIDTH_LOG + 1;

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             error_q, error_d;
    logic [WIDTH:0]   trial;
    logic             q_bit;

    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        q_bit   = 1'b0;
        // Next partial remainder: shift in the top bit of the remaining dividend.
        trial   = {rem_q, quo_q[WIDTH-1]};
        if (cnt_q != '0) begin
            if (trial >= {1'b0, b_q}) begin
                rem_d = WIDTH'(trial - {1'b0, b_q});
                q_bit = 1'b1;
            end else begin
                rem_d = trial[WIDTH-1:0];
            end
            // The quotient register doubles as the dividend shift register.
            quo_d = {quo_q[WIDTH-2:0], q_bit};
            cnt_d = cnt_q - 1'b1;
        end else if (go) begin
            if (b == '0) begin
                quo_d   = '1;
                rem_d   = a;
                error_d = 1'b1;
            end else begin
                quo_d   = a;
                rem_d   = '0;
                b_d     = b;
                cnt_d   = CW'(WIDTH);
                error_d = 1'b0;
            end
        end
        // ready is registered from the next state so it reflects go immediately.
        ready_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q   <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
        end else begin
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign div   = quo_q;
    assign mod   = rem_q;
    assign ready = ready_q;
    assign error = error_q;

endmodule

// File: rtl/divmod_arb_rr_pick.sv
// Round-robin picker: first set mask bit at or after ptr, wrapping past NREQ-1.
// Latency: combinational.
// Backpressure: none; any=0 when the mask is empty.
//
// Ports:
//   mask   eligible requesters
//   ptr    search start position, must be < NREQ
//   gnt    one-hot winner (0 when any=0)
//   id     winner index (0 when any=0)
//   any    at least one mask bit set
module rr_pick #(
    parameter int NREQ = 4,
    localparam int PW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] mask,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   id,
    output logic            any
);

    int          sum;
    logic [PW-1:0] idx;

    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        sum = 0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Wrap explicitly so non-power-of-two NREQ works.
            sum = int'(ptr) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = PW'(sum);
            if (!any && mask[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                id       = idx;
            end
        end
    end

endmodule

// File: rtl/divmod_arb.sv
// Round-robin arbiter sharing one divmod unit among NREQ requesters.
// Latency: capture 1 cycle after req; done at capture+2 (b==0) or capture+WIDTH+2.
// Backpressure: requesters hold req until their done bit; no preemption of an in-flight op.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (also resets the divider)
//   req           level request per requester
//   a_in, b_in    flattened operands, requester i at [i*WIDTH +: WIDTH]
//   gnt           one-hot owner of the in-flight operation, 0 when idle
//   done          one-hot single-cycle completion pulse
//   busy          high from capture until done
//   err           divide-by-zero flag, valid with done
//   div, mod      quotient/remainder, valid with done and held afterwards
module divmod_arb
    import divmod_arb_pkg::*;
#(
    parameter int WIDTH_LOG = 4,
    parameter int NREQ = 4,
    localparam int WIDTH = width_of(WIDTH_LOG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  err,
    output logic [WIDTH-1:0]      div,
    output logic [WIDTH-1:0]      mod
);

    localparam int PW = $clog2(NREQ);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    arb_state_t       state_q, state_d;
    logic [PW-1:0]    id_q, id_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    op_t              op_q, op_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] mod_q, mod_d;

    op_t              req_op [NREQ];
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  pick_gnt;
    logic [PW-1:0]    pick_id;
    logic             pick_any;

    logic             dm_go;
    logic [WIDTH-1:0] dm_div;
    logic [WIDTH-1:0] dm_mod;
    logic             dm_ready;
    logic             dm_error;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_op[i].a = a_in[i*WIDTH +: WIDTH];
        assign req_op[i].b = b_in[i*WIDTH +: WIDTH];
    end

    // A requester being acknowledged this cycle still has req high; masking it
    // keeps it from being re-granted on stale request state.
    assign elig = req & ~done_q;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .mask (elig),
        .ptr  (ptr_q),
        .gnt  (pick_gnt),
        .id   (pick_id),
        .any  (pick_any)
    );

    // The divider idles with ready=1 during IDLE/ISSUE, so go never collides
    // with a computation in progress.
    assign dm_go = (state_q == ST_ISSUE);

    divmod #(
        .WIDTH_LOG (WIDTH_LOG)
    ) u_divmod (
        .clk   (clk),
        .rst   (rst),
        .go    (dm_go),
        .a     (op_q.a),
        .b     (op_q.b),
        .div   (dm_div),
        .mod   (dm_mod),
        .ready (dm_ready),
        .error (dm_error)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        busy_d  = busy_q;
        err_d   = err_q;
        div_d   = div_q;
        mod_d   = mod_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    id_d    = pick_id;
                    op_d    = req_op[pick_id];
                    gnt_d   = pick_gnt;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // ready is already valid in the first WAIT cycle: either 0
                // (computing) or 1 with error for a zero divisor.
                if (dm_ready) begin
                    div_d   = dm_div;
                    mod_d   = dm_mod;
                    err_d   = dm_error;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (id_q == PW'(NREQ - 1)) ? '0 : id_q + PW'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            ptr_q   <= '0;
            op_q    <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            div_q   <= '0;
            mod_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            div_q   <= div_d;
            mod_q   <= mod_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;
    assign err  = err_q;
    assign div  = div_q;
    assign mod  = mod_q;

endmodule

// File: tb/tb_divmod_arb.sv
// Self-checking bench for divmod_arb: transaction-level model plus directed vectors.
// Latency: n/a.
// Backpressure: n/a.
module tb_divmod_arb;

    localparam int WL = 4;
    localparam int W  = 16;
    localparam int N  = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  a_in;
    logic [N*W-1:0]  b_in;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            busy;
    logic            err;
    logic [W-1:0]    div;
    logic [W-1:0]    mod;

    divmod_arb #(
        .WIDTH_LOG (WL),
        .NREQ      (N)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .a_in (a_in),
        .b_in (b_in),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .err  (err),
        .div  (div),
        .mod  (mod)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit stim_done = 1'b0;

    // Model state: one operation in flight at most, counted down to completion.
    bit           m_busy = 1'b0;
    int           m_id   = 0;
    int           m_ptr  = 0;
    int           m_left = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [N-1:0] m_gnt  = '0;
    logic [N-1:0] m_done = '0;
    logic         m_err  = 1'b0;
    logic [W-1:0] m_div  = '0;
    logic [W-1:0] m_mod  = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        logic [N-1:0]   elig;
        logic [N-1:0]   elig_sh;
        logic [N*W-1:0] sh;
        bit             found;
        int             idx;
        if (rst) begin
            m_busy = 1'b0; m_gnt = '0; m_done = '0; m_err = 1'b0;
            m_div = '0; m_mod = '0; m_ptr = 0; m_left = 0;
        end else begin
            elig   = req & ~m_done;
            m_done = '0;
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx     = (m_ptr + k) % N;
                    elig_sh = elig >> idx;
                    if (!found && elig_sh[0]) begin
                        found  = 1'b1;
                        m_id   = idx;
                        sh     = a_in >> (idx * W);
                        m_a    = sh[W-1:0];
                        sh     = b_in >> (idx * W);
                        m_b    = sh[W-1:0];
                        m_left = (m_b == '0) ? 2 : W + 2;
                        m_busy = 1'b1;
                        m_gnt  = N'(1 << idx);
                    end
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_gnt  = '0;
                    m_done = N'(1 << m_id);
                    m_err  = (m_b == '0);
                    if (m_b != '0) begin
                        m_div = m_a / m_b;
                        m_mod = m_a % m_b;
                    end
                    m_ptr = (m_id + 1) % N;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        chk("gnt", gnt, m_gnt);
        chk("done", done, m_done);
        chk("busy", busy, m_busy);
        chk("err", err, m_err);
        if (m_done != '0 && !m_err) begin
            chk("div", div, m_div);
            chk("mod", mod, m_mod);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [N*W-1:0] keep;
        keep = ~({{(N*W-W){1'b0}}, {W{1'b1}}} << (i * W));
        a_in = (a_in & keep) | ({{(N*W-W){1'b0}}, a} << (i * W));
        b_in = (b_in & keep) | ({{(N*W-W){1'b0}}, b} << (i * W));
    endtask

    // Waits (bounded) for a done pulse; cyc counts negedges waited.
    task automatic wait_done(output logic [N-1:0] d, output int cyc);
        d   = '0;
        cyc = 0;
        while (d == '0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            d = done;
        end
        if (d == '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: no done within 200 cycles at %0t", $time);
        end
    endtask

    task automatic run_stim();
        logic [N-1:0] d;
        logic [N-1:0] e;
        int           cyc;

        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div", div, 0);
        rst = 1'b0;
        @(negedge clk);

        // Requester 0: 100 / 7 = 14 r 2, done 19 cycles after req.
        set_op(0, 16'd100, 16'd7);
        req = 4'b0001;
        @(negedge clk);
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_busy", busy, 1);
        wait_done(d, cyc);
        chk("t1_lat", cyc + 1, 19);
        chk("t1_done", d, 4'b0001);
        chk("t1_div", div, 14);
        chk("t1_mod", mod, 2);
        chk("t1_err", err, 0);
        req = '0;
        repeat (2) @(negedge clk);

        // Requester 2 divides by zero: done exactly 3 cycles after req.
        set_op(2, 16'd5, 16'd0);
        req = 4'b0100;
        wait_done(d, cyc);
        chk("t2_lat", cyc, 3);
        chk("t2_done", d, 4'b0100);
        chk("t2_err", err, 1);
        req = '0;
        repeat (2) @(negedge clk);

        // All four from reset: 0xFF / 0x10 = 15 r 15, served in order 0..3.
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 16'h00FF, 16'h0010);
        req = 4'b1111;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            wait_done(d, cyc);
            e = N'(1 << k);
            chk("t3_order", d, e);
            chk("t3_div", div, 15);
            chk("t3_mod", mod, 15);
            req = req & ~d;
        end
        repeat (2) @(negedge clk);

        // Requester 1 keeps requesting while 3 joins: order 1, 3, 1, 1.
        set_op(1, 16'd50, 16'd6);
        set_op(3, 16'd60, 16'd7);
        req = 4'b0010;
        wait_done(d, cyc);
        chk("t4_first", d, 4'b0010);
        chk("t4_div1", div, 8);
        req = 4'b1010;
        wait_done(d, cyc);
        chk("t4_second", d, 4'b1000);
        chk("t4_mod3", mod, 4);
        req = 4'b0010;
        wait_done(d, cyc);
        chk("t4_third", d, 4'b0010);
        @(negedge clk);
        chk("t4_no_dup", gnt, 0);
        @(negedge clk);
        chk("t4_regrant", gnt, 4'b0010);
        wait_done(d, cyc);
        chk("t4_fourth", d, 4'b0010);
        req = '0;
        repeat (2) @(negedge clk);

        // Operands change and req drops right after capture: 200 / 9 = 22 r 2.
        set_op(0, 16'd200, 16'd9);
        req = 4'b0001;
        @(negedge clk);
        set_op(0, 16'd1, 16'd1);
        req = '0;
        wait_done(d, cyc);
        chk("t5_done", d, 4'b0001);
        chk("t5_div", div, 22);
        chk("t5_mod", mod, 2);
        repeat (2) @(negedge clk);

        // Reset during WAIT aborts; afterwards the pointer starts at 0 again.
        set_op(1, 16'd1000, 16'd3);
        req = 4'b0010;
        repeat (6) @(negedge clk);
        chk("t6_busy_pre", busy, 1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("t6_gnt", gnt, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        chk("t6_div", div, 0);
        chk("t6_mod", mod, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_quiet", done, 0);
        set_op(0, 16'd1000, 16'd3);
        set_op(1, 16'd77, 16'd5);
        req = 4'b0011;
        @(negedge clk);
        chk("t6_gnt0", gnt, 4'b0001);
        wait_done(d, cyc);
        chk("t6_done0", d, 4'b0001);
        chk("t6_div0", div, 333);
        chk("t6_mod0", mod, 1);
        req = 4'b0010;
        wait_done(d, cyc);
        chk("t6_done1", d, 4'b0010);
        chk("t6_div1", div, 15);
        chk("t6_mod1", mod, 2);
        req = '0;
        repeat (3) @(negedge clk);
        stim_done = 1'b1;
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        fork
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    model_step();
                end
            end
            begin
                while (!stim_done) begin
                    @(negedge clk);
                    compare_outputs();
                end
            end
            run_stim();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
